aes_out_pack: RTL and testbench
===============================

Name: aes_out_pack

Overview:
Downstream stage of cipher_eng. Collects the 32-bit ciphertext words cipher_eng emits on data_out/dvalid_out, assembles each group of four words into one 128-bit block, and buffers blocks in a small FIFO. The FIFO drains over a valid/ready handshake to the system side. Also reports progress, fill level and sticky overflow for debug/status registers.

Parameters:
DEPTH, 2, number of 128-bit blocks the output FIFO holds (power of 2, >=2)
CNT_W, 16, width of the accepted-block counter

Ports:
clk_in  input  1  clock, all logic on rising edge
rst_in  input  1  asynchronous, active-low reset
en_in  input  1  global enable, same net as cipher_eng en_in
clr_in  input  1  synchronous flush of assembler, FIFO and status
data_in  input  32  ciphertext word from cipher_eng data_out
dvalid_in  input  1  word valid from cipher_eng dvalid_out
block_out  output  128  head-of-FIFO block; first word received sits in [127:96]
bvalid_out  output  1  block_out holds a valid block
bready_in  input  1  consumer accepts block_out this cycle
word_cnt_out  output  2  words held in assembler (0..3)
level_out  output  $clog2(DEPTH)+1  blocks in FIFO (0..DEPTH)
overflow_out  output  1  sticky: a completed block was dropped
blk_cnt_out  output  CNT_W  blocks pushed into FIFO, wraps

Behaviour:
- Reset (rst_in=0, async): block_out=0, bvalid_out=0, word_cnt_out=0, level_out=0, overflow_out=0, blk_cnt_out=0, assembler register=0. Reset in the middle of a block discards the partial words.
- Word accept: dvalid_in=1 and en_in=1 at a rising edge. Then assembler <= {assembler[95:0], data_in} and word_cnt increments mod 4. With en_in=0, dvalid_in is ignored. The output handshake keeps working regardless of en_in.
- Gaps between words are allowed. No timeout exists; a partial block waits indefinitely.
- Block complete: the edge that accepts a word while word_cnt=3. The pushed block is {assembler[95:0], data_in}, and word_cnt returns to 0 on that edge.
- Push:
  - Not full: push, increment blk_cnt_out.
  - Full with a pop on the same edge: push and pop both occur, level unchanged.
  - Full without a pop: block is dropped, overflow_out<=1 (sticky until clr_in/reset), blk_cnt_out unchanged.
- Pop: bvalid_out=1 and bready_in=1 at an edge. Head advances. bready_in with bvalid_out=0 has no effect.
- Output is FWFT from registered FIFO storage. block_out/bvalid_out are valid the cycle after the completing edge when the FIFO was empty. Minimum push-to-bvalid latency is 1 cycle.
- Full throughput is one word per cycle in and one block per 4 cycles out, with no bubbles when bready_in=1.
- block_out holds its value while bvalid_out=1 and bready_in=0. When bvalid_out=0, block_out is don't-care; the bench must not check it.
- level_out = pushes − pops. Read and write pointers wrap modulo DEPTH, and a full flag is kept separately.
- blk_cnt_out wraps from 2^CNT_W−1 to 0 with no flag.
- clr_in=1: next edge sets word_cnt=0, empties the FIFO (bvalid_out=0), and clears overflow_out and blk_cnt_out. clr_in has priority over a simultaneous word accept or pop; both are ignored.
- No combinational path from any input to any output.

Test Plan:
- FIPS-197 AES-128 vector:
  - Stimulus: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on consecutive cycles, bready_in=1.
  - Response: one cycle after the 4th word, block_out=69c4e0d86a7b0430d8cdb78070b4c55a with bvalid_out=1 for exactly one cycle; blk_cnt_out=1; level_out returns to 0.
- Gapped input plus enable gating:
  - Stimulus: 00112233, idle 3 cycles, 44556677 with en_in=0, then 44556677, 8899aabb, ccddeeff with en_in=1.
  - Response: word_cnt_out steps 1,1,2,3,0; block=00112233445566778899aabbccddeeff.
- Back-pressure and overflow (DEPTH=2):
  - Stimulus: bready_in=0, three full blocks A, B, C.
  - Response: level_out=2, overflow_out=1 after C's 4th word, blk_cnt_out=2.
  - Then bready_in=1: A then B on consecutive cycles, then bvalid_out=0.
- Simultaneous push/pop when full:
  - Stimulus: FIFO holds 2, bready_in=1 on the same edge block D completes.
  - Response: no overflow, level_out stays 2, output order preserved ending with D.
- Reset mid-block:
  - Stimulus: 2 words accepted, rst_in low 1 cycle, then 4 words 11111111, 22222222, 33333333, 44444444.
  - Response: all outputs 0 during reset; block=11111111222222223333333344444444.
- clr_in priority:
  - Stimulus: FIFO holds 1 block, overflow_out=1, clr_in=1 on the same edge as a word accept and a pop.
  - Response: next cycle level_out=0, word_cnt_out=0, overflow_out=0, blk_cnt_out=0, bvalid_out=0.

Source files
------------

// File: rtl/aes_out_pack.sv
// Packs 32-bit ciphertext words from cipher_eng into 128-bit blocks and buffers
// them in a small first-word-fall-through FIFO drained by a valid/ready handshake.
module aes_out_pack #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     en_in,
    input  logic                     clr_in,
    input  logic [31:0]              data_in,
    input  logic                     dvalid_in,
    output logic [127:0]             block_out,
    output logic                     bvalid_out,
    input  logic                     bready_in,
    output logic [1:0]               word_cnt_out,
    output logic [$clog2(DEPTH):0]   level_out,
    output logic                     overflow_out,
    output logic [CNT_W-1:0]         blk_cnt_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [95:0]       asm_q;
    logic [1:0]        word_cnt_q;
    logic [127:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              full_q;
    logic              full_d;
    logic              overflow_q;
    logic [CNT_W-1:0]  blk_cnt_q;

    logic accept;
    logic complete;
    logic pop;
    logic push;
    logic drop;

    // NOTE: every always_comb output gets a value on every path, so no latches appear.
    always_comb begin
        accept   = en_in && dvalid_in && !clr_in;
        complete = accept && (word_cnt_q == 2'd3);
        pop      = !clr_in && bready_in && (level_q != '0);
        // A full FIFO still accepts a block when the head leaves on the same edge.
        push     = complete && (!full_q || pop);
        drop     = complete && full_q && !pop;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d   = (level_d == LVL_W'(DEPTH));
    end

    // NOTE: storage is reset here only because block_out must read zero during reset;
    // the FIFO is tiny, so clearing it costs little.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            asm_q      <= '0;
            word_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            blk_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_in) begin
            asm_q      <= '0;
            word_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            if (accept) begin
                asm_q      <= {asm_q[63:0], data_in};
                word_cnt_q <= word_cnt_q + 2'd1;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= {asm_q, data_in};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                blk_cnt_q       <= blk_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            level_q <= level_d;
            full_q  <= full_d;
        end
    end

    assign block_out    = mem_q[rd_ptr_q];
    assign bvalid_out   = (level_q != '0);
    assign word_cnt_out = word_cnt_q;
    assign level_out    = level_q;
    assign overflow_out = overflow_q;
    assign blk_cnt_out  = blk_cnt_q;

endmodule

// File: tb/tb_aes_out_pack.sv
// Directed bench for aes_out_pack: a reference model tracks words, FIFO contents
// and status; blocks are queued on completion and compared when popped.
module tb_aes_out_pack;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          en_in = 1'b1;
    logic          clr_in = 1'b0;
    logic [31:0]   data_in = '0;
    logic          dvalid_in = 1'b0;
    logic [127:0]  block_out;
    logic          bvalid_out;
    logic          bready_in = 1'b0;
    logic [1:0]    word_cnt_out;
    logic [1:0]    level_out;
    logic          overflow_out;
    logic [15:0]   blk_cnt_out;

    aes_out_pack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .en_in        (en_in),
        .clr_in       (clr_in),
        .data_in      (data_in),
        .dvalid_in    (dvalid_in),
        .block_out    (block_out),
        .bvalid_out   (bvalid_out),
        .bready_in    (bready_in),
        .word_cnt_out (word_cnt_out),
        .level_out    (level_out),
        .overflow_out (overflow_out),
        .blk_cnt_out  (blk_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int            tests = 0;
    int            fails = 0;
    logic [127:0]  sb_q[$];
    int            m_cnt = 0;
    logic [95:0]   m_asm = '0;
    logic          m_ov = 1'b0;
    logic [15:0]   m_blk = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt = 0;
        m_asm = '0;
        m_ov  = 1'b0;
        m_blk = '0;
    endtask

    // Called at a falling edge with inputs already applied; advances one clock.
    task automatic cycle();
        logic         pop_m;
        logic [127:0] blk;
        pop_m = !clr_in && bready_in && (sb_q.size() != 0);
        check("bvalid", bvalid_out, sb_q.size() != 0);
        if (pop_m) begin
            blk = sb_q.pop_front();
            check("pop_block", block_out, blk);
        end
        if (clr_in) begin
            model_reset();
        end else if (en_in && dvalid_in) begin
            if (m_cnt == 3) begin
                blk = {m_asm, data_in};
                if (sb_q.size() < DEPTH) begin
                    sb_q.push_back(blk);
                    m_blk++;
                end else begin
                    m_ov = 1'b1;
                end
            end
            m_asm = {m_asm[63:0], data_in};
            m_cnt = (m_cnt + 1) % 4;
        end
        @(posedge clk_in);
        @(negedge clk_in);
        check("word_cnt", word_cnt_out, m_cnt);
        check("level", level_out, sb_q.size());
        check("overflow", overflow_out, m_ov);
        check("blk_cnt", blk_cnt_out, m_blk);
    endtask

    task automatic send_word(input logic [31:0] w);
        data_in   = w;
        dvalid_in = 1'b1;
        cycle();
        dvalid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_block(input logic [7:0] tag);
        for (int i = 0; i < 4; i++) send_word({tag, 24'(i)});
    endtask

    function automatic logic [127:0] blk_of(input logic [7:0] tag);
        return {tag, 24'd0, tag, 24'd1, tag, 24'd2, tag, 24'd3};
    endfunction

    task automatic check_reset_outputs();
        check("rst_block", block_out, 128'd0);
        check("rst_bvalid", bvalid_out, 1'b0);
        check("rst_word_cnt", word_cnt_out, 2'd0);
        check("rst_level", level_out, 2'd0);
        check("rst_overflow", overflow_out, 1'b0);
        check("rst_blk_cnt", blk_cnt_out, 16'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs();
        rst_in = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // FIPS-197 ciphertext, consumer always ready
        bready_in = 1'b1;
        send_word(32'h69c4e0d8);
        send_word(32'h6a7b0430);
        send_word(32'hd8cdb780);
        send_word(32'h70b4c55a);
        check("fips_bvalid", bvalid_out, 1'b1);
        check("fips_block", block_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("fips_blk_cnt", blk_cnt_out, 16'd1);
        cycle();
        check("fips_bvalid_gone", bvalid_out, 1'b0);
        check("fips_level0", level_out, 2'd0);

        // Gapped words with an enable-gated word in between
        send_word(32'h00112233);
        check("gap_cnt1", word_cnt_out, 2'd1);
        idle(3);
        check("gap_cnt_idle", word_cnt_out, 2'd1);
        en_in = 1'b0;
        send_word(32'h44556677);
        check("gap_en_off", word_cnt_out, 2'd1);
        en_in = 1'b1;
        send_word(32'h44556677);
        check("gap_cnt2", word_cnt_out, 2'd2);
        send_word(32'h8899aabb);
        check("gap_cnt3", word_cnt_out, 2'd3);
        send_word(32'hccddeeff);
        check("gap_cnt0", word_cnt_out, 2'd0);
        check("gap_block", block_out, 128'h00112233445566778899aabbccddeeff);
        cycle();

        // Back-pressure and overflow
        clr_in = 1'b1;
        cycle();
        clr_in    = 1'b0;
        bready_in = 1'b0;
        send_block(8'hA0);
        send_block(8'hB0);
        send_block(8'hC0);
        check("bp_level", level_out, 2'd2);
        check("bp_overflow", overflow_out, 1'b1);
        check("bp_blk_cnt", blk_cnt_out, 16'd2);
        check("bp_head_A", block_out, blk_of(8'hA0));
        bready_in = 1'b1;
        cycle();
        check("bp_head_B", block_out, blk_of(8'hB0));
        cycle();
        check("bp_drained", bvalid_out, 1'b0);

        // Push and pop on the same edge while full
        clr_in = 1'b1;
        cycle();
        clr_in    = 1'b0;
        bready_in = 1'b0;
        send_block(8'hE1);
        send_block(8'hE2);
        for (int i = 0; i < 3; i++) send_word({8'hD0, 24'(i)});
        bready_in = 1'b1;
        send_word({8'hD0, 24'd3});
        check("pp_no_overflow", overflow_out, 1'b0);
        check("pp_level", level_out, 2'd2);
        check("pp_head_E2", block_out, blk_of(8'hE2));
        cycle();
        check("pp_head_D", block_out, blk_of(8'hD0));
        cycle();
        check("pp_drained", bvalid_out, 1'b0);

        // Reset in the middle of a block
        send_word(32'h55555555);
        send_word(32'h66666666);
        do_reset();
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        check("rst_mid_bvalid", bvalid_out, 1'b1);
        check("rst_mid_block", block_out, 128'h11111111222222223333333344444444);
        cycle();

        // clr_in wins over a simultaneous word accept and pop
        bready_in = 1'b0;
        send_block(8'h61);
        send_block(8'h62);
        send_block(8'h63);
        bready_in = 1'b1;
        send_word(32'h77777777);
        check("clr_pre_level", level_out, 2'd1);
        check("clr_pre_overflow", overflow_out, 1'b1);
        check("clr_pre_word_cnt", word_cnt_out, 2'd1);
        clr_in    = 1'b1;
        data_in   = 32'h88888888;
        dvalid_in = 1'b1;
        cycle();
        clr_in    = 1'b0;
        dvalid_in = 1'b0;
        check("clr_level", level_out, 2'd0);
        check("clr_word_cnt", word_cnt_out, 2'd0);
        check("clr_overflow", overflow_out, 1'b0);
        check("clr_blk_cnt", blk_cnt_out, 16'd0);
        check("clr_bvalid", bvalid_out, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
